seq_add_rr_arbiter: RTL and testbench

- Shares one registered WIDTH-bit add-constant datapath (out = in + INCR) among NUM_REQ ready/valid requesters.
- Round-robin arbitration; one transaction accepted per cycle at most.
- Result is registered and tagged with the winning requester index.
- Sits in front of the sequential add stage; each requester sees a standard ready/valid producer port.

---
 rtl/seq_add_rr_arbiter.sv | 133 +++++++++++++
 tb/tb_seq_add_rr_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_add_rr_arbiter.sv
// seq_add_rr_arbiter
// Round-robin arbiter that shares one registered add-constant stage
// (O0 = operand + INCR, mod 2^WIDTH) among NUM_REQ ready/valid requesters.
// At most one operand is accepted per cycle. The result is tagged with the
// index of the requester that won.
//
// Ports:
//   CLK            clock, all state on the rising edge
//   RESETN         asynchronous active-low reset
//   CE             clock enable; low freezes the arbiter and output register
//   I0             packed operands, requester i in [i*WIDTH +: WIDTH]
//   valid_data_in  per-requester operand valid
//   ready_data_in  per-requester accept, one-hot or zero (combinational)
//   O0             registered result
//   O0_tag         requester index that produced O0
//   valid_data_out O0/O0_tag valid
//   ready_data_out downstream accepts O0
//   O0_ovf         carry-out of the add (only with SEQ_ADD_ARB_OVF_EN)
//
// Optional feature macro: SEQ_ADD_ARB_OVF_EN adds the registered O0_ovf port.
module seq_add_rr_arbiter #(
    parameter int               NUM_REQ = 4,
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] INCR    = WIDTH'(1),
    parameter int               TAG_W   = $clog2(NUM_REQ)
) (
    input  logic                     CLK,
    input  logic                     RESETN,
    input  logic                     CE,
    input  logic [NUM_REQ*WIDTH-1:0] I0,
    input  logic [NUM_REQ-1:0]       valid_data_in,
    output logic [NUM_REQ-1:0]       ready_data_in,
    output logic [WIDTH-1:0]         O0,
    output logic [TAG_W-1:0]         O0_tag,
    output logic                     valid_data_out,
    input  logic                     ready_data_out
`ifdef SEQ_ADD_ARB_OVF_EN
    ,
    output logic                     O0_ovf
`endif
);

    logic               r_run;
    logic [TAG_W-1:0]   r_ptr;
    logic [WIDTH-1:0]   r_o0;
    logic [TAG_W-1:0]   r_tag;
    logic               r_valid;

    logic               w_can_accept;
    logic               w_gnt_any;
    logic [TAG_W-1:0]   w_gnt_idx;
    logic [TAG_W-1:0]   w_next_ptr;
    logic [NUM_REQ-1:0] w_gnt_oh;
    logic [WIDTH-1:0]   w_opnd;
    logic [WIDTH:0]     w_sum;
    int                 w_idx;

    // r_run is a one-stage release synchroniser: it rises on the first edge
    // after RESETN deasserts, so the earliest grant lands on the second edge.
    assign w_can_accept = r_run & CE & (~r_valid | ready_data_out);

    // Search valid requesters starting at the priority pointer, wrapping.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        w_gnt_oh  = '0;
        w_opnd    = '0;
        w_idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (!w_gnt_any && valid_data_in[w_idx]) begin
                w_gnt_any       = 1'b1;
                w_gnt_idx       = TAG_W'(w_idx);
                w_gnt_oh[w_idx] = 1'b1;
                w_opnd          = I0[w_idx*WIDTH +: WIDTH];
            end
        end
        if (!w_can_accept) begin
            w_gnt_any = 1'b0;
            w_gnt_oh  = '0;
        end
    end

    assign w_next_ptr    = (w_gnt_idx == TAG_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + TAG_W'(1);
    assign w_sum         = {1'b0, w_opnd} + {1'b0, INCR};
    assign ready_data_in = w_gnt_oh;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_run   <= 1'b0;
            r_ptr   <= '0;
            r_o0    <= '0;
            r_tag   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (w_gnt_any) begin
                // Covers simultaneous drain and accept: overwrite, stay valid.
                r_o0    <= w_sum[WIDTH-1:0];
                r_tag   <= w_gnt_idx;
                r_valid <= 1'b1;
                r_ptr   <= w_next_ptr;
            end else if (CE && r_valid && ready_data_out) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign O0             = r_o0;
    assign O0_tag         = r_tag;
    assign valid_data_out = r_valid;

`ifdef SEQ_ADD_ARB_OVF_EN
    logic r_ovf;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_ovf <= 1'b0;
        end else if (w_gnt_any) begin
            r_ovf <= w_sum[WIDTH];
        end
    end

    assign O0_ovf = r_ovf;
`else
    logic w_unused_carry;
    assign w_unused_carry = w_sum[WIDTH];
`endif

endmodule

// File: tb/tb_seq_add_rr_arbiter.sv
// Testbench for seq_add_rr_arbiter (default parameters: 4 requesters,
// 8-bit data, INCR=1). A transaction-level model tracks the priority pointer
// and the output register; one process compares the DUT against it every
// cycle, and the directed sequence pins the model with literal expectations.
module tb_seq_add_rr_arbiter;
    localparam int N   = 4;
    localparam int W   = 8;
    localparam int INC = 1;

    logic           CLK = 1'b0;
    logic           RESETN;
    logic           CE;
    logic [N*W-1:0] I0;
    logic [N-1:0]   vin;
    logic [N-1:0]   rin;
    logic [W-1:0]   O0;
    logic [1:0]     tag;
    logic           vout;
    logic           rout;
`ifdef SEQ_ADD_ARB_OVF_EN
    logic           ovf;
`endif

    seq_add_rr_arbiter dut (
        .CLK            (CLK),
        .RESETN         (RESETN),
        .CE             (CE),
        .I0             (I0),
        .valid_data_in  (vin),
        .ready_data_in  (rin),
        .O0             (O0),
        .O0_tag         (tag),
        .valid_data_out (vout),
        .ready_data_out (rout)
`ifdef SEQ_ADD_ARB_OVF_EN
        ,
        .O0_ovf         (ovf)
`endif
    );

    always #5 CLK = ~CLK;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model state
    int       m_ptr   = 0;
    int       m_o     = 0;
    int       m_tag   = 0;
    bit       m_valid = 0;
    bit       m_ovf   = 0;
    bit       m_run   = 0;
    int       c_j;
    int       c_s;
    logic [N-1:0] c_rdy;

    // Compare just before each rising edge, then advance the model across it.
    always begin
        @(negedge CLK);
        #2;
        if (!RESETN) begin
            m_ptr = 0; m_o = 0; m_tag = 0; m_valid = 0; m_ovf = 0; m_run = 0;
            chk("rst_vout", 32'(vout), 0);
            chk("rst_o0", 32'(O0), 0);
            chk("rst_tag", 32'(tag), 0);
            chk("rst_rdy", 32'(rin), 0);
`ifdef SEQ_ADD_ARB_OVF_EN
            chk("rst_ovf", 32'(ovf), 0);
`endif
        end else begin
            chk("vout", 32'(vout), 32'(m_valid));
            chk("o0", 32'(O0), 32'(m_o));
            chk("tag", 32'(tag), 32'(m_tag));
`ifdef SEQ_ADD_ARB_OVF_EN
            chk("ovf", 32'(ovf), 32'(m_ovf));
`endif
            c_j = -1;
            if (m_run && CE && (!m_valid || rout)) begin
                for (int k = 0; k < N; k++) begin
                    if (c_j < 0 && vin[(m_ptr + k) % N]) c_j = (m_ptr + k) % N;
                end
            end
            c_rdy = '0;
            if (c_j >= 0) c_rdy[c_j] = 1'b1;
            chk("rdy_in", 32'(rin), 32'(c_rdy));
            if (c_j >= 0) begin
                c_s     = int'(I0[c_j*W +: W]) + INC;
                m_o     = c_s % (1 << W);
                m_ovf   = (c_s >= (1 << W));
                m_tag   = c_j;
                m_valid = 1;
                m_ptr   = (c_j + 1) % N;
            end else if (CE && m_valid && rout) begin
                m_valid = 0;
            end
            m_run = 1;
        end
    end

    task automatic do_reset();
        @(negedge CLK);
        RESETN = 1'b0;
        @(negedge CLK);
        RESETN = 1'b1;
        @(posedge CLK);
    endtask

    initial begin
        RESETN = 1'b0;
        CE     = 1'b1;
        rout   = 1'($urandom);
        vin    = 4'hF;
        I0     = $urandom;

        // Reset state with requesters asking
        repeat (3) @(negedge CLK);
        #1;
        chk("lit_rst_vout", 32'(vout), 0);
        chk("lit_rst_o0", 32'(O0), 0);
        chk("lit_rst_tag", 32'(tag), 0);
        chk("lit_rst_rdy", 32'(rin), 0);

        // Release: first transfer on the second edge
        @(negedge CLK);
        RESETN = 1'b1;
        vin    = 4'b0010;
        I0     = $urandom;
        I0[15:8] = 8'h10;
        rout   = 1'b1;
        @(posedge CLK); #1;
        chk("lit_sync_no_grant", 32'(vout), 0);
        @(posedge CLK); #1;
        chk("lit_first_o0", 32'(O0), 32'h11);
        chk("lit_first_tag", 32'(tag), 1);
        chk("lit_first_vout", 32'(vout), 1);

        // Round robin with everyone valid
        do_reset();
        @(negedge CLK);
        vin = 4'hF;
        I0  = {8'h30, 8'h20, 8'h10, 8'h00};
        for (int k = 0; k < 7; k++) begin
            @(posedge CLK); #1;
            chk("lit_rr_tag", 32'(tag), 32'(k % 4));
            chk("lit_rr_o0", 32'(O0), 32'(16 * (k % 4) + 1));
        end

        // Backpressure holding O0=21, then resume at ptr=3
        @(negedge CLK);
        rout = 1'b0;
        repeat (3) begin
            #1 chk("lit_bp_rdy", 32'(rin), 0);
            @(posedge CLK); #1;
            chk("lit_bp_o0", 32'(O0), 32'h21);
            chk("lit_bp_tag", 32'(tag), 2);
            chk("lit_bp_vout", 32'(vout), 1);
            @(negedge CLK);
        end
        rout = 1'b1;
        #1 chk("lit_bp_resume_rdy", 32'(rin), 32'b1000);
        @(posedge CLK); #1;
        chk("lit_bp_resume_o0", 32'(O0), 32'h31);
        chk("lit_bp_resume_tag", 32'(tag), 3);

        // Wrap-around of the adder
        @(negedge CLK);
        vin = 4'b0100;
        I0  = $urandom;
        I0[23:16] = 8'hFF;
        @(posedge CLK); #1;
        chk("lit_wrap_o0", 32'(O0), 32'h00);
        chk("lit_wrap_tag", 32'(tag), 2);
`ifdef SEQ_ADD_ARB_OVF_EN
        chk("lit_wrap_ovf", 32'(ovf), 1);
`endif
        @(negedge CLK);
        I0[23:16] = 8'hFE;
        @(posedge CLK); #1;
        chk("lit_fe_o0", 32'(O0), 32'hFF);
        chk("lit_fe_tag", 32'(tag), 2);
`ifdef SEQ_ADD_ARB_OVF_EN
        chk("lit_fe_ovf", 32'(ovf), 0);
`endif

        // Clock-enable gating
        @(negedge CLK);
        CE  = 1'b0;
        vin = 4'b0001;
        I0[7:0] = 8'h42;
        repeat (2) begin
            #1 chk("lit_ce_rdy", 32'(rin), 0);
            @(posedge CLK); #1;
            chk("lit_ce_o0", 32'(O0), 32'hFF);
            chk("lit_ce_tag", 32'(tag), 2);
            chk("lit_ce_vout", 32'(vout), 1);
            @(negedge CLK);
        end
        CE = 1'b1;
        #1 chk("lit_ce_on_rdy", 32'(rin), 32'b0001);
        @(posedge CLK); #1;
        chk("lit_ce_on_o0", 32'(O0), 32'h43);
        chk("lit_ce_on_tag", 32'(tag), 0);

        // Async reset between edges while a result is held
        #2;
        RESETN = 1'b0;
        #1;
        chk("lit_async_vout", 32'(vout), 0);
        chk("lit_async_o0", 32'(O0), 0);
        @(negedge CLK);
        @(negedge CLK);
        RESETN = 1'b1;
        vin = 4'hF;
        I0  = {8'h30, 8'h20, 8'h10, 8'h00};
        @(posedge CLK);
        @(posedge CLK); #1;
        chk("lit_ptr_reset_tag", 32'(tag), 0);
        chk("lit_ptr_reset_o0", 32'(O0), 32'h01);

        // Randomized traffic against the model
        repeat (400) begin
            @(negedge CLK);
            vin  = 4'($urandom);
            I0   = $urandom;
            rout = ($urandom_range(0, 9) < 7);
            CE   = ($urandom_range(0, 9) < 9);
        end

        @(negedge CLK);
        #3;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
